fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one synchronous FIFO write interface among NUM_REQ producers. It sits directly in front of the FIFO: it registers the winner's data onto the FIFO `wr_en`/`data_in`, throttles on `full`/`almostfull` so that no write is ever issued into a full FIFO, and routes the FIFO's `wr_ack`/`overflow` back to the requester that owns each write.

---
 rtl/fifo_wr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ producers
//
// Purpose: picks one requesting producer per cycle (round-robin), registers its data
// onto the FIFO write port, throttles on full/almostfull so no write lands in a full
// FIFO, and steers the FIFO's wr_ack/overflow back to the producer that owns the write.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   arb_en               high allows new grants; low lets the in-flight write finish
//   req, req_data        per-producer request and data (producer i at [i*FIFO_WIDTH +: FIFO_WIDTH])
//   full, almostfull     FIFO flags
//   wr_ack, overflow     FIFO registered write response (cycle after the write edge)
//   gnt                  registered one-hot grant pulse
//   req_ack, req_nack    one-hot write confirmation / overflow report per producer
//   ovf_err              sticky overflow flag
//   wr_en, data_in       registered FIFO write port
//   wr_count             (FIFO_ARB_STATS_EN only) saturating count of acked writes
//
// Optional feature macro: FIFO_ARB_STATS_EN

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    input  logic                          full,
    input  logic                          almostfull,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            req_nack,
    output logic                          ovf_err,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]                   wr_count,
`endif
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || FIFO_DEPTH < 2) begin : g_param_check
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and FIFO_DEPTH at least 2");
    end

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0] data_in_q, data_in_d;
    logic [PTR_W-1:0]      own1_q, own1_d;
    logic [PTR_W-1:0]      own2_q, own2_d;
    logic                  v2_q, v2_d;
    logic                  ovf_err_q, ovf_err_d;

    logic [NUM_REQ-1:0]    elig;
    logic                  issue;
    logic                  found;
    logic [PTR_W-1:0]      win;
    int                    idx;

    // A producer granted last cycle is still holding req; masking it stops a double win.
    assign elig  = req & ~gnt_q;
    // If the write already in flight will make the FIFO full, do not issue another.
    assign issue = arb_en && !full && !(wr_en_q && almostfull);

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && elig[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = '0;
        wr_en_d   = 1'b0;
        data_in_d = data_in_q;
        own1_d    = own1_q;
        if (issue && found) begin
            wr_en_d    = 1'b1;
            gnt_d[win] = 1'b1;
            data_in_d  = req_data[int'(win)*FIFO_WIDTH +: FIFO_WIDTH];
            own1_d     = win;
            rr_ptr_d   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
        end
        // Owner and valid follow the write one stage so they line up with the FIFO response.
        own2_d    = own1_q;
        v2_d      = wr_en_q;
        ovf_err_d = ovf_err_q | overflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            wr_en_q   <= 1'b0;
            data_in_q <= '0;
            own1_q    <= '0;
            own2_q    <= '0;
            v2_q      <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            data_in_q <= data_in_d;
            own1_q    <= own1_d;
            own2_q    <= own2_d;
            v2_q      <= v2_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    // Responses with no write in flight (v2 low) are not attributed to anyone.
    always_comb begin
        req_ack  = '0;
        req_nack = '0;
        if (wr_ack && v2_q) begin
            req_ack[own2_q] = 1'b1;
        end
        if (overflow && v2_q) begin
            req_nack[own2_q] = 1'b1;
        end
    end

    assign gnt     = gnt_q;
    assign wr_en   = wr_en_q;
    assign data_in = data_in_q;
    assign ovf_err = ovf_err_q;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        if (|req_ack && wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with a behavioural FIFO
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 8;

    typedef struct packed {
        logic [N-1:0] g;
        logic [W-1:0] d;
    } wr_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           arb_en = 1'b0;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           full, almostfull, wr_ack, overflow;
    logic [N-1:0]   gnt, req_ack, req_nack;
    logic           ovf_err, wr_en;
    logic [W-1:0]   data_in;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]    wr_count;
`endif

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .req_data(req_data),
        .full(full), .almostfull(almostfull), .wr_ack(wr_ack), .overflow(overflow),
        .gnt(gnt), .req_ack(req_ack), .req_nack(req_nack), .ovf_err(ovf_err),
`ifdef FIFO_ARB_STATS_EN
        .wr_count(wr_count),
`endif
        .wr_en(wr_en), .data_in(data_in)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: occupancy counter with registered write response.
    int   cnt = 0;
    logic ack_m = 1'b0, ovf_m = 1'b0, rd_en = 1'b0, inj = 1'b0;

    always @(posedge clk) begin
        ack_m <= wr_en && (cnt < D);
        ovf_m <= wr_en && (cnt == D);
        if (wr_en && cnt < D && !(rd_en && cnt > 0)) cnt <= cnt + 1;
        else if (!(wr_en && cnt < D) && rd_en && cnt > 0) cnt <= cnt - 1;
    end

    assign full       = (cnt == D);
    assign almostfull = (cnt == D - 1);
    assign wr_ack     = ack_m & ~inj;
    assign overflow   = ovf_m | inj;

    int passed = 0;
    int total  = 0;
    int viol_full = 0, viol_consec = 0, wr_cycles = 0;

    wr_t          exp_wr[$];
    logic [N-1:0] exp_ack[$];
    logic [N-1:0] exp_nack[$];
    logic [W-1:0] prod_q[N][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Producers: hold req/data until granted, then move to the next queued item.
    initial begin
        req = '0;
        req_data = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (gnt[i] && prod_q[i].size() != 0) void'(prod_q[i].pop_front());
                req[i] = (prod_q[i].size() != 0);
                req_data[i*W +: W] = (prod_q[i].size() != 0) ? prod_q[i][0] : '0;
            end
        end
    end

    // Monitor: compare DUT outputs against the scoreboard queues.
    logic [N-1:0] gnt_prev = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_cycles++;
                if (exp_wr.size() == 0) chk("unexpected_wr", {gnt, data_in}, 0);
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_gnt_data", {gnt, data_in}, {e.g, e.d});
                end
            end
            if (|req_ack) begin
                if (exp_ack.size() == 0) chk("unexpected_ack", req_ack, 0);
                else chk("req_ack", req_ack, exp_ack.pop_front());
            end
            if (|req_nack) begin
                if (exp_nack.size() == 0) chk("unexpected_nack", req_nack, 0);
                else chk("req_nack", req_nack, exp_nack.pop_front());
            end
            if (wr_en && full) viol_full++;
            if ((gnt & gnt_prev) != '0) viol_consec++;
        end
        gnt_prev = gnt;
    end

    function automatic bit busy();
        bit b;
        b = (exp_wr.size() != 0) || (exp_ack.size() != 0) || (exp_nack.size() != 0);
        for (int i = 0; i < N; i++) if (prod_q[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy() && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) chk({name, "_timeout"}, 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        rd_en = 1'b1;
        while ((cnt != 0 || exp_ack.size() != 0) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        rd_en = 1'b0;
        if (k >= 200) chk("drain_timeout", 0, 1);
    endtask

    task automatic push_wr(input logic [N-1:0] g, input logic [W-1:0] d);
        wr_t e;
        e.g = g;
        e.d = d;
        exp_wr.push_back(e);
        exp_ack.push_back(g);
    endtask

    initial begin
        int k, snap;
        // Reset with all producers requesting.
        rst_n = 1'b0;
        arb_en = 1'b1;
        for (int i = 0; i < N; i++) prod_q[i].push_back(16'hA000 + 16'(i));
        repeat (3) @(negedge clk);
        chk("rst_req_seen", req, 4'b1111);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_ovf_err", ovf_err, 0);

        // Round-robin from producer 0 on consecutive cycles.
        for (int i = 0; i < N; i++) push_wr(4'(1 << i), 16'hA000 + 16'(i));
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle("rr");
`ifdef FIFO_ARB_STATS_EN
        chk("wr_count", wr_count, 4);
`endif
        drain();

        // Single producer, 9 writes, no reads: 8 land, 9th held.
        for (int j = 1; j <= 9; j++) prod_q[0].push_back(16'(j));
        for (int j = 1; j <= 8; j++) push_wr(4'b0001, 16'(j));
        repeat (30) @(posedge clk);
        #1;
        chk("thr_fifo_count", cnt, 8);
        chk("thr_ninth_held", prod_q[0].size(), 1);
        chk("thr_ovf_err", ovf_err, 0);
        push_wr(4'b0001, 16'd9);
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        wait_idle("thr");
        chk("thr_count_after_read", cnt, 8);
        chk("thr_no_wr_full", viol_full, 0);
        drain();

        // Two producers back-to-back: almostfull rule must stop at exactly 8.
        for (int j = 0; j < 5; j++) begin
            prod_q[0].push_back(16'h1000 + 16'(j));
            prod_q[1].push_back(16'h1100 + 16'(j));
        end
        for (int j = 0; j < 4; j++) begin
            push_wr(4'b0010, 16'h1100 + 16'(j));
            push_wr(4'b0001, 16'h1000 + 16'(j));
        end
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_fifo_count", cnt, 8);
        chk("b2b_ovf_err", ovf_err, 0);
        chk("b2b_left0", prod_q[0].size(), 1);
        chk("b2b_left1", prod_q[1].size(), 1);
        push_wr(4'b0010, 16'h1104);
        push_wr(4'b0001, 16'h1004);
        drain();
        wait_idle("b2b");
        chk("b2b_no_wr_full", viol_full, 0);
        drain();

        // Single requester: never granted on consecutive cycles.
        for (int j = 0; j < 4; j++) begin
            prod_q[2].push_back(16'h2200 + 16'(j));
            push_wr(4'b0100, 16'h2200 + 16'(j));
        end
        wait_idle("single");
        chk("single_no_consec", viol_consec, 0);
        drain();

        // arb_en drop right after a grant.
        prod_q[3].push_back(16'h3300);
        prod_q[1].push_back(16'h3100);
        push_wr(4'b1000, 16'h3300);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (gnt == '0 && k < 50);
        if (k >= 50) chk("arb_gnt_timeout", 0, 1);
        arb_en = 1'b0;
        snap = wr_cycles;
        repeat (8) @(posedge clk);
        #1;
        chk("arb_off_wr_cycles", wr_cycles - snap, 1);
        chk("arb_off_ack_done", exp_ack.size(), 0);
        chk("arb_off_p1_held", prod_q[1].size(), 1);
        push_wr(4'b0010, 16'h3100);
        arb_en = 1'b1;
        wait_idle("arb");
        drain();

        // Overflow injected on producer 1's response cycle.
        prod_q[1].push_back(16'h5100);
        begin
            wr_t e;
            e.g = 4'b0010;
            e.d = 16'h5100;
            exp_wr.push_back(e);
        end
        exp_nack.push_back(4'b0010);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (gnt[1] == 1'b0 && k < 50);
        if (k >= 50) chk("ovf_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        inj = 1'b1;
        @(posedge clk); #1;
        inj = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_err_set", ovf_err, 1);
        chk("ovf_nack_done", exp_nack.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_err_sticky", ovf_err, 1);
        rst_n = 1'b0;
        #2;
        chk("ovf_err_cleared", ovf_err, 0);
        chk("reset_wr_en", wr_en, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain();

        chk("left_wr", exp_wr.size(), 0);
        chk("left_ack", exp_ack.size(), 0);
        chk("left_nack", exp_nack.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

endmodule
